// File: rtl/note_voice_player.sv
// note_voice_player
//   Polyphonic note voice allocator/timer. Each voice holds an active bit,
//   a note index, a metadata tag and a remaining-beat counter. A new_note
//   strobe loads the lowest-index voice that is free at the start of the
//   cycle. Active voices count down on beats while play is asserted.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   play          1 = voices count down, 0 = counters and active bits frozen
//   beat          one-cycle beat tick
//   new_note      one-cycle strobe: note/duration/metadata valid
//   note          note index to play
//   duration      note length in beats (0 = finish immediately)
//   metadata      per-note attribute stored with the voice
//   voice_note    packed note per voice, voice i at [6i+5:6i]
//   voice_meta    packed metadata per voice, voice i at [3i+2:3i]
//   voice_active  1 = voice i sounding
//   note_done     registered pulse: one or more voices finished / zero-length note
//   note_dropped  registered pulse: a new_note found no free voice
module note_voice_player #(
    parameter int NUM_VOICES = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      beat,
    input  logic                      new_note,
    input  logic [5:0]                note,
    input  logic [5:0]                duration,
    input  logic [2:0]                metadata,
    output logic [6*NUM_VOICES-1:0]   voice_note,
    output logic [3*NUM_VOICES-1:0]   voice_meta,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic                      note_done,
    output logic                      note_dropped
);

    logic [NUM_VOICES-1:0]       active_q;
    logic [NUM_VOICES-1:0][5:0]  note_q;
    logic [NUM_VOICES-1:0][2:0]  meta_q;
    logic [NUM_VOICES-1:0][5:0]  cnt_q;

    logic [NUM_VOICES-1:0]       load_sel;
    logic [NUM_VOICES-1:0]       finish;
    logic [NUM_VOICES-1:0]       dec_en;
    logic                        found;
    logic                        valid_note;
    logic                        done_next;
    logic                        drop_next;

    // Allocation looks only at the registered active bits, so a voice that
    // finishes this cycle is not yet visible as free.
    always_comb begin
        load_sel   = '0;
        finish     = '0;
        dec_en     = '0;
        found      = 1'b0;
        valid_note = new_note && (duration != 6'd0);
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!active_q[i] && !found) begin
                load_sel[i] = valid_note;
                found       = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            dec_en[i] = active_q[i] && !load_sel[i] && beat && play
                        && (cnt_q[i] != 6'd0);
            finish[i] = dec_en[i] && (cnt_q[i] == 6'd1);
        end
        done_next = (|finish) || (new_note && (duration == 6'd0));
        drop_next = valid_note && !found;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q     <= '0;
            note_q       <= '0;
            meta_q       <= '0;
            cnt_q        <= '0;
            note_done    <= 1'b0;
            note_dropped <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (load_sel[i]) begin
                    active_q[i] <= 1'b1;
                    note_q[i]   <= note;
                    meta_q[i]   <= metadata;
                    cnt_q[i]    <= duration;
                end else if (dec_en[i]) begin
                    cnt_q[i] <= cnt_q[i] - 6'd1;
                    if (finish[i]) begin
                        active_q[i] <= 1'b0;
                    end
                end
            end
            note_done    <= done_next;
            note_dropped <= drop_next;
        end
    end

    assign voice_note   = note_q;
    assign voice_meta   = meta_q;
    assign voice_active = active_q;

endmodule

// File: tb/tb_note_voice_player.sv
// Directed self-checking bench for note_voice_player (3 voices).
module tb_note_voice_player;

    logic        clk;
    logic        reset;
    logic        play;
    logic        beat;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic [2:0]  metadata;
    logic [17:0] voice_note;
    logic [8:0]  voice_meta;
    logic [2:0]  voice_active;
    logic        note_done;
    logic        note_dropped;

    int checks;
    int errors;

    note_voice_player #(.NUM_VOICES(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .beat         (beat),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .metadata     (metadata),
        .voice_note   (voice_note),
        .voice_meta   (voice_meta),
        .voice_active (voice_active),
        .note_done    (note_done),
        .note_dropped (note_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        play     = 1'b1;
        beat     = 1'b0;
        new_note = 1'b0;
        note     = '0;
        duration = '0;
        metadata = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // One-cycle strobe, returns with strobe cleared after the capturing edge.
    task automatic strobe(input logic [5:0] n, input logic [5:0] d, input logic [2:0] m);
        new_note = 1'b1;
        note     = n;
        duration = d;
        metadata = m;
        step();
        new_note = 1'b0;
    endtask

    task automatic tick();
        beat = 1'b1;
        step();
        beat = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        strobe(6'd17, 6'd5, 3'd6);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (voice_active !== 3'b000) begin errors++; $display("FAIL reset_active: got %b expected 000", voice_active); end
        checks++; if (voice_note !== 18'd0) begin errors++; $display("FAIL reset_note: got %0h expected 0", voice_note); end
        checks++; if (voice_meta !== 9'd0) begin errors++; $display("FAIL reset_meta: got %0h expected 0", voice_meta); end
        checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", note_done); end
        checks++; if (note_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", note_dropped); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_note();
        do_reset();
        strobe(6'd12, 6'd3, 3'd5);
        checks++; if (voice_active !== 3'b001) begin errors++; $display("FAIL single_load_active: got %b expected 001", voice_active); end
        checks++; if (voice_note[5:0] !== 6'd12) begin errors++; $display("FAIL single_load_note: got %0d expected 12", voice_note[5:0]); end
        checks++; if (voice_meta[2:0] !== 3'd5) begin errors++; $display("FAIL single_load_meta: got %0d expected 5", voice_meta[2:0]); end
        tick(); step();
        tick();
        checks++; if (voice_active !== 3'b001 || note_done !== 1'b0) begin errors++; $display("FAIL single_after2: active %b done %b expected 001 0", voice_active, note_done); end
        step();
        tick();
        checks++; if (voice_active !== 3'b000) begin errors++; $display("FAIL single_end_active: got %b expected 000", voice_active); end
        checks++; if (note_done !== 1'b1) begin errors++; $display("FAIL single_end_done: got %b expected 1", note_done); end
        step();
        checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", note_done); end
        checks++; if (voice_note[5:0] !== 6'd12) begin errors++; $display("FAIL single_retain_note: got %0d expected 12", voice_note[5:0]); end
    endtask

    task automatic test_alloc_full();
        do_reset();
        strobe(6'd5, 6'd4, 3'd1);
        strobe(6'd7, 6'd4, 3'd2);
        strobe(6'd9, 6'd4, 3'd3);
        checks++; if (voice_active !== 3'b111) begin errors++; $display("FAIL full_active: got %b expected 111", voice_active); end
        checks++; if (voice_note !== {6'd9, 6'd7, 6'd5}) begin errors++; $display("FAIL full_notes: got %0h expected %0h", voice_note, {6'd9, 6'd7, 6'd5}); end
        checks++; if (voice_meta !== {3'd3, 3'd2, 3'd1}) begin errors++; $display("FAIL full_meta: got %0h expected %0h", voice_meta, {3'd3, 3'd2, 3'd1}); end
        strobe(6'd11, 6'd4, 3'd4);
        checks++; if (note_dropped !== 1'b1) begin errors++; $display("FAIL full_dropped: got %b expected 1", note_dropped); end
        checks++; if (voice_active !== 3'b111 || voice_note !== {6'd9, 6'd7, 6'd5}) begin errors++; $display("FAIL full_unchanged: active %b notes %0h", voice_active, voice_note); end
        step();
        checks++; if (note_dropped !== 1'b0) begin errors++; $display("FAIL full_drop_width: got %b expected 0", note_dropped); end
    endtask

    task automatic test_multi_done();
        do_reset();
        strobe(6'd1, 6'd2, 3'd0);
        strobe(6'd2, 6'd5, 3'd0);
        strobe(6'd3, 6'd2, 3'd0);
        tick(); step();
        tick();
        checks++; if (voice_active !== 3'b010) begin errors++; $display("FAIL multi_active: got %b expected 010", voice_active); end
        checks++; if (note_done !== 1'b1) begin errors++; $display("FAIL multi_done: got %b expected 1", note_done); end
        step();
        checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL multi_done_width: got %b expected 0", note_done); end
    endtask

    task automatic test_pause();
        do_reset();
        strobe(6'd30, 6'd4, 3'd2);
        tick(); tick();
        play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); step();
        end
        checks++; if (voice_active !== 3'b001 || note_done !== 1'b0) begin errors++; $display("FAIL pause_hold: active %b done %b expected 001 0", voice_active, note_done); end
        strobe(6'd20, 6'd1, 3'd7);
        checks++; if (voice_active !== 3'b011 || voice_note[11:6] !== 6'd20) begin errors++; $display("FAIL pause_load: active %b note %0d expected 011 20", voice_active, voice_note[11:6]); end
        tick();
        checks++; if (voice_active !== 3'b011) begin errors++; $display("FAIL pause_beat_ignored: got %b expected 011", voice_active); end
        play = 1'b1;
        step();
        tick();
        checks++; if (voice_active !== 3'b001 || note_done !== 1'b1) begin errors++; $display("FAIL resume_first: active %b done %b expected 001 1", voice_active, note_done); end
        tick();
        checks++; if (voice_active !== 3'b000 || note_done !== 1'b1) begin errors++; $display("FAIL resume_end: active %b done %b expected 000 1", voice_active, note_done); end
    endtask

    task automatic test_beat_coincident();
        do_reset();
        beat = 1'b1;
        strobe(6'd44, 6'd2, 3'd1);
        beat = 1'b0;
        checks++; if (voice_active !== 3'b001) begin errors++; $display("FAIL coinc_load: got %b expected 001", voice_active); end
        tick();
        checks++; if (voice_active !== 3'b001) begin errors++; $display("FAIL coinc_one_beat: got %b expected 001", voice_active); end
        tick();
        checks++; if (voice_active !== 3'b000 || note_done !== 1'b1) begin errors++; $display("FAIL coinc_end: active %b done %b expected 000 1", voice_active, note_done); end
        step();
        strobe(6'd50, 6'd0, 3'd3);
        checks++; if (note_done !== 1'b1 || voice_active !== 3'b000) begin errors++; $display("FAIL zero_dur: done %b active %b expected 1 000", note_done, voice_active); end
        step();
        checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL zero_dur_width: got %b expected 0", note_done); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        strobe(6'd10, 6'd1, 3'd0);
        strobe(6'd21, 6'd9, 3'd0);
        strobe(6'd22, 6'd9, 3'd0);
        beat = 1'b1;
        strobe(6'd33, 6'd3, 3'd6);
        beat = 1'b0;
        checks++; if (note_dropped !== 1'b1 || note_done !== 1'b1) begin errors++; $display("FAIL race_pulses: dropped %b done %b expected 1 1", note_dropped, note_done); end
        checks++; if (voice_active !== 3'b110) begin errors++; $display("FAIL race_active: got %b expected 110", voice_active); end
        strobe(6'd33, 6'd3, 3'd6);
        checks++; if (voice_active !== 3'b111 || voice_note[5:0] !== 6'd33) begin errors++; $display("FAIL race_reload: active %b note %0d expected 111 33", voice_active, voice_note[5:0]); end
        checks++; if (note_dropped !== 1'b0 || note_done !== 1'b0) begin errors++; $display("FAIL race_quiet: dropped %b done %b expected 0 0", note_dropped, note_done); end
    endtask

    task automatic test_reset_midnote();
        // Voices left active by the previous test.
        #2;
        reset = 1'b0;
        #1;
        checks++; if (voice_active !== 3'b000) begin errors++; $display("FAIL midreset_active: got %b expected 000", voice_active); end
        beat = 1'b1;
        step();
        beat = 1'b0;
        checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", note_done); end
        reset = 1'b1;
        step();
        strobe(6'd40, 6'd2, 3'd4);
        checks++; if (voice_active !== 3'b001 || voice_note[5:0] !== 6'd40) begin errors++; $display("FAIL midreset_reload: active %b note %0d expected 001 40", voice_active, voice_note[5:0]); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        play     = 1'b0;
        beat     = 1'b0;
        new_note = 1'b0;
        note     = '0;
        duration = '0;
        metadata = '0;
        test_reset();
        test_single_note();
        test_alloc_full();
        test_multi_done();
        test_pause();
        test_beat_coincident();
        test_back_to_back();
        test_reset_midnote();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_voice_player.md
NOTE_VOICE_PLAYER -- requirements
Module: note_voice_player

Interface
REQ-001 Parameter NUM_VOICES, default 3, number of concurrent note voices (range 1-4).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 play  input  1  1 = voices count down; 0 = paused, all counters frozen.
REQ-005 beat  input  1  one-cycle tick, 48 per second, from the beat generator.
REQ-006 new_note  input  1  one-cycle strobe from the song reader: note/duration/metadata valid this cycle.
REQ-007 note  input  6  note index to play.
REQ-008 duration  input  6  note length in beats.
REQ-009 metadata  input  3  per-note attribute, stored with the voice.
REQ-010 voice_note  output  6*NUM_VOICES  packed note index per voice; voice i at bits [6i+5:6i].
REQ-011 voice_meta  output  3*NUM_VOICES  packed metadata per voice.
REQ-012 voice_active  output  NUM_VOICES  1 = voice i currently sounding.
REQ-013 note_done  output  1  one-cycle pulse when one or more voices finish.
REQ-014 note_dropped  output  1  one-cycle pulse when a new_note could not be placed.

Function
REQ-015 Each voice SHALL hold: active bit, 6-bit note, 3-bit metadata, 6-bit remaining-beat counter.
REQ-016 On new_note=1 with duration!=0, the block SHALL load the lowest-index voice that is inactive at the start of that cycle; voice_active/voice_note/voice_meta SHALL reflect it the next cycle (1-cycle latency).
REQ-017 The loaded counter SHALL equal duration; a voice loaded in a cycle SHALL NOT decrement on that same cycle's beat.
REQ-018 On new_note=1 with duration==0, no voice SHALL be loaded and note_done SHALL pulse the next cycle.
REQ-019 On new_note=1 with all voices active, the note SHALL be discarded, no voice state SHALL change, and note_dropped SHALL pulse the next cycle.
REQ-020 On beat=1 and play=1, every active voice not being loaded that cycle SHALL decrement its counter by 1.
REQ-021 A voice whose counter decrements from 1 to 0 SHALL clear its active bit at that edge; note_done SHALL pulse for exactly one cycle aligned with voice_active falling.
REQ-022 Multiple voices finishing on the same beat SHALL produce a single one-cycle note_done pulse.
REQ-023 A voice freed in cycle N SHALL NOT be allocatable until cycle N+1; new_note arriving in cycle N with no other free voice SHALL be dropped.
REQ-024 When play=0, counters and active bits SHALL hold; beats SHALL be ignored; new_note SHALL still be accepted and loaded.
REQ-025 Inactive voices SHALL retain their last note/meta values; consumers SHALL qualify with voice_active.
REQ-026 note_done and note_dropped SHALL each be registered outputs; both MAY pulse in the same cycle.
REQ-027 Counter arithmetic SHALL be 6-bit unsigned with no wrap: an active voice never decrements below 0.

Reset
REQ-028 While reset=0, all voice_active SHALL be 0, all counters/note/meta 0, note_done=0, note_dropped=0, asynchronously.
REQ-029 Reset asserted mid-note SHALL silence all voices immediately with no note_done pulse; first strobe after release SHALL load voice 0.

Verification
REQ-030 Reset release, play=1, new_note note=12 dur=3 -> next cycle voice_active=001, voice_note[5:0]=12; after 3 beats voice_active=000 with one note_done pulse on that edge.
REQ-031 Three strobes note=5,7,9 dur=4 on consecutive cycles, then a fourth note=11 -> voices 0,1,2 hold 5,7,9; fourth gives note_dropped pulse, voice_active=111 unchanged.
REQ-032 Voices 0 and 2 loaded dur=2 same beat window -> both clear on the same edge, single one-cycle note_done.
REQ-033 Voice dur=4 active, play=0 for 10 beats then play=1 -> counter frozen at pause value; completes after the remaining beats only.
REQ-034 new_note dur=2 coincident with beat -> voice loaded with 2, needs two further beats; new_note dur=0 -> no voice loaded, note_done pulses next cycle.
REQ-035 Voice finishing on cycle N with all others busy and new_note in cycle N -> note_dropped; same strobe at N+1 -> loaded into freed voice.
